mpc_constraint_seq: RTL

Controller that sequences up to N_STAGES constraint-fill sub-pipelines of the dense MPC constraint builder (bound rows, rate rows, slack rows). Each sub-pipeline uses the ap_ctrl_hs handshake. The block starts the stages one at a time, in index order, skipping any stage whose enable bit is clear. It also owns the single write port of the shared h vector memory and grants that port only to the running stage.

---
 rtl/mpc_ctrl_pkg.sv | 19 +
 rtl/mpc_hport_mux.sv | 40 ++++
 rtl/mpc_constraint_seq.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mpc_ctrl_pkg.sv
// Shared types and constants for the MPC constraint-fill sequencer.
// Holds the controller state encoding, the default bound value and the index width.
package mpc_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StRun,
    StWait,
    StDone
  } state_e;

  localparam int unsigned N_STAGES_DEF = 4;
  localparam int unsigned IDXW = $clog2(N_STAGES_DEF);

  // 10.0 in Q16.16
  localparam logic [31:0] BOUND_DEF_Q16 = 32'd655360;

endpackage

// File: rtl/mpc_hport_mux.sv
// N-to-1 grant mux for the shared h write port.
// Any access from a child that does not hold the grant is dropped and flagged on viol.
module mpc_hport_mux #(
  parameter int unsigned N  = 4,
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32,
  parameter int unsigned IW = 2
) (
  input  logic [IW-1:0]   sel,
  input  logic            valid,
  input  logic [N*AW-1:0] child_h_address0,
  input  logic [N-1:0]    child_h_ce0,
  input  logic [N-1:0]    child_h_we0,
  input  logic [N*DW-1:0] child_h_d0,
  output logic [AW-1:0]   h_address0,
  output logic            h_ce0,
  output logic            h_we0,
  output logic [DW-1:0]   h_d0,
  output logic            viol
);

  always_comb begin
    h_address0 = '0;
    h_ce0      = 1'b0;
    h_we0      = 1'b0;
    h_d0       = '0;
    viol       = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (valid && (sel == IW'(k))) begin
        h_address0 = child_h_address0[k*AW +: AW];
        h_ce0      = child_h_ce0[k];
        h_we0      = child_h_we0[k];
        h_d0       = child_h_d0[k*DW +: DW];
      end else if (child_h_ce0[k] || child_h_we0[k]) begin
        viol = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mpc_constraint_seq.sv
// Sequences the constraint-fill sub-pipelines one at a time in index order over ap_ctrl_hs,
// skipping disabled stages, and grants the shared h write port to the running stage only.
module mpc_constraint_seq
  import mpc_ctrl_pkg::*;
#(
  parameter int unsigned N_STAGES = N_STAGES_DEF,
  parameter int unsigned AW       = 5,
  parameter int unsigned DW       = 32
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic                         ap_start,
  output logic                         ap_done,
  output logic                         ap_idle,
  output logic                         ap_ready,
  input  logic [N_STAGES-1:0]          stage_en,
  output logic [$clog2(N_STAGES)-1:0]  cur_stage,
  output logic                         err,
  output logic [N_STAGES-1:0]          child_start,
  input  logic [N_STAGES-1:0]          child_ready,
  input  logic [N_STAGES-1:0]          child_done,
  input  logic [N_STAGES*AW-1:0]       child_h_address0,
  input  logic [N_STAGES-1:0]          child_h_ce0,
  input  logic [N_STAGES-1:0]          child_h_we0,
  input  logic [N_STAGES*DW-1:0]       child_h_d0,
  output logic [AW-1:0]                h_address0,
  output logic                         h_ce0,
  output logic                         h_we0,
  output logic [DW-1:0]                h_d0
);

  localparam int unsigned IW = $clog2(N_STAGES);

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [N_STAGES-1:0] mask_q, mask_d;
  logic                err_q, err_d;
  logic                last, cur_ready, cur_done, grant, viol;

  assign last      = (idx_q == IW'(N_STAGES - 1));
  assign cur_ready = child_ready[idx_q];
  assign cur_done  = child_done[idx_q];
  assign grant     = (state_q == StRun) || (state_q == StWait);

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    err_d   = err_q | viol;
    unique case (state_q)
      StIdle: begin
        if (ap_start) begin
          mask_d  = stage_en;
          idx_d   = '0;
          // Accepting a start clears history, but a stray access in this very cycle still counts.
          err_d   = viol;
          state_d = StSelect;
        end
      end
      StSelect: begin
        if (mask_q[idx_q]) begin
          state_d = StRun;
        end else if (last) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      StRun: begin
        if (cur_ready && cur_done) begin
          if (last) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = StSelect;
          end
        end else if (cur_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (cur_done) begin
          if (last) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = StSelect;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    child_start = '0;
    if ((state_q == StRun) && !ap_rst) begin
      child_start[idx_q] = 1'b1;
    end
    ap_done   = (state_q == StDone);
    ap_ready  = (state_q == StDone);
    ap_idle   = (state_q == StIdle) && !ap_start && !ap_rst;
    cur_stage = idx_q;
    err       = err_q;
  end

  mpc_hport_mux #(
    .N  (N_STAGES),
    .AW (AW),
    .DW (DW),
    .IW (IW)
  ) u_hport_mux (
    .sel              (idx_q),
    .valid            (grant),
    .child_h_address0 (child_h_address0),
    .child_h_ce0      (child_h_ce0),
    .child_h_we0      (child_h_we0),
    .child_h_d0       (child_h_d0),
    .h_address0       (h_address0),
    .h_ce0            (h_ce0),
    .h_we0            (h_we0),
    .h_d0             (h_d0),
    .viol             (viol)
  );

endmodule
